// File: rtl/seq_mul4_pkg.sv
// Shared constants and state encoding for the 4-bit sequential shift-add multiplier.
package seq_mul4_pkg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned ITERS = 4;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mul4_cra.sv
// 4-bit ripple-carry adder (CRA) built from full-adder cells.
module seq_mul4_cra
    import seq_mul4_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[WIDTH];

endmodule

// File: rtl/seq_mul4.sv
// Unsigned 4x4 sequential shift-add multiplier: one adder pass per cycle, four iterations.
module seq_mul4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    import seq_mul4_pkg::*;

    state_e state_q, state_d;

    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic load;
    logic step;
    logic fin;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] next_acc;
    logic [WIDTH-1:0] next_q;

    // Multiplicand is added only when the current multiplier LSB is set.
    assign addend = q_q[0] ? m_q : '0;

    seq_mul4_cra u_cra (
        .a     (acc_q),
        .b     (addend),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (carry)
    );

    // Carry-out becomes the top bit of the shifted partial product.
    assign next_acc = {carry, sum[WIDTH-1:1]};
    assign next_q   = {sum[0], q_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    load    = 1'b1;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d = DONE;
                    fin     = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture and one shift-add iteration per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            q_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            m_q   <= a;
            q_q   <= b;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (step) begin
            acc_q <= next_acc;
            q_q   <= next_q;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Status flags track the state being entered so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            p    <= '0;
        end else begin
            busy <= (state_d != IDLE);
            done <= (state_d == DONE);
            if (fin) begin
                p <= {next_acc, next_q};
            end
        end
    end

endmodule

// File: tb/tb_seq_mul4.sv
// Directed self-checking bench for seq_mul4.
module tb_seq_mul4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int         n_cmp;
    int         n_fail;
    logic [7:0] exp_p;

    seq_mul4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One full operation with per-cycle checks of busy, done and p hold.
    task automatic run_op(input logic [3:0] ra, input logic [3:0] rb,
                          input logic [7:0] rexp, input string tag);
        a     = ra;
        b     = rb;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~ra;
        b     = ~rb;
        chk({tag, "_busy0"}, 8'(busy), 8'd1);
        chk({tag, "_done0"}, 8'(done), 8'd0);
        chk({tag, "_hold0"}, p, exp_p);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, "_busy"}, 8'(busy), 8'd1);
            chk({tag, "_done"}, 8'(done), 8'd0);
            chk({tag, "_hold"}, p, exp_p);
        end
        tick();
        chk({tag, "_done_hi"}, 8'(done), 8'd1);
        chk({tag, "_busy_dn"}, 8'(busy), 8'd1);
        chk({tag, "_p"}, p, rexp);
        exp_p = rexp;
        tick();
        chk({tag, "_done_lo"}, 8'(done), 8'd0);
        chk({tag, "_idle"}, 8'(busy), 8'd0);
        chk({tag, "_p_kept"}, p, exp_p);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        exp_p  = 8'h00;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = 4'd0;
        b      = 4'd0;

        #3;
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_p", p, 8'h00);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;

        // First edge after reset release accepts the start.
        run_op(4'd13, 4'd11, 8'h8F, "m13x11");
        run_op(4'd15, 4'd15, 8'hE1, "m15x15");
        run_op(4'd0, 4'd9, 8'h00, "m0x9");
        run_op(4'd9, 4'd1, 8'h09, "m9x1");

        // Starts during CALC and DONE must be ignored.
        a = 4'd5; b = 4'd6; start = 1'b1;
        tick();
        a = 4'd2; b = 4'd2;
        chk("ign_busy", 8'(busy), 8'd1);
        tick();
        start = 1'b0;
        chk("ign_calc_done", 8'(done), 8'd0);
        tick();
        tick();
        chk("ign_hold", p, 8'h09);
        tick();
        chk("ign_done_hi", 8'(done), 8'd1);
        chk("ign_p", p, 8'h1E);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_done_lo", 8'(done), 8'd0);
        chk("ign_idle", 8'(busy), 8'd0);
        tick();
        chk("ign_no_restart", 8'(busy), 8'd0);
        chk("ign_no_pulse", 8'(done), 8'd0);
        chk("ign_p_kept", p, 8'h1E);

        // Back-to-back with start held high; operands switch after acceptance.
        a = 4'd3; b = 4'd7; start = 1'b1;
        tick();
        a = 4'd12; b = 4'd12;
        chk("b2b_busy1", 8'(busy), 8'd1);
        repeat (3) tick();
        chk("b2b_hold1", p, 8'h1E);
        tick();
        chk("b2b_done1", 8'(done), 8'd1);
        chk("b2b_p1", p, 8'h15);
        tick();
        chk("b2b_gap_busy", 8'(busy), 8'd0);
        chk("b2b_gap_done", 8'(done), 8'd0);
        tick();
        start = 1'b0;
        chk("b2b_reaccept", 8'(busy), 8'd1);
        repeat (3) tick();
        chk("b2b_hold2", p, 8'h15);
        chk("b2b_nodone", 8'(done), 8'd0);
        tick();
        chk("b2b_done2", 8'(done), 8'd1);
        chk("b2b_p2", p, 8'h90);
        tick();
        chk("b2b_idle", 8'(busy), 8'd0);
        exp_p = 8'h90;

        // Reset mid-operation aborts and clears outputs immediately.
        a = 4'd10; b = 4'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 8'(busy), 8'd0);
        chk("mid_rst_done", 8'(done), 8'd0);
        chk("mid_rst_p", p, 8'h00);
        exp_p = 8'h00;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_done", 8'(done), 8'd0);
            chk("post_rst_busy", 8'(busy), 8'd0);
        end
        run_op(4'd10, 4'd10, 8'h64, "m10x10");

        for (int i = 0; i < 256; i++) begin
            run_op(4'(i / 16), 4'(i % 16), 8'((i / 16) * (i % 16)), "sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
